// File: rtl/cpu_step_controller_pkg.sv
// cpu_ctrl_defs: mode/state encodings and width helpers shared by the step controller
package cpu_ctrl_defs;
  localparam int STEP_W = 16;
  typedef enum logic [1:0] {
    MODE_CYC   = 2'b00,
    MODE_INSTR = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CYC,
    S_INSTR_P,
    S_INSTR_W,
    S_RUN,
    S_HALTED
  } state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cpu_step_controller_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and one-cycle press pulse
module btn_debounce import cpu_ctrl_defs::*; #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  // level follows the synchronised key only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: turns debounced key presses into cpu_step enables (cycle, instruction, free-run, hold)
module cpu_step_controller import cpu_ctrl_defs::*; #(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int RUN_DIV          = 50_000_000,
  parameter int MAX_INSTR_PULSES = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Button,
  input  logic [1:0]        mode,
  input  logic              instr_done,
  input  logic              halt,
  output logic              cpu_step,
  output logic              busy,
  output logic              running,
  output logic              fault,
  output logic [STEP_W-1:0] step_cnt
);
  localparam int DW = cnt_w(RUN_DIV);
  localparam int PW = cnt_w(MAX_INSTR_PULSES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  localparam logic [PW-1:0] P_MAX = PW'(MAX_INSTR_PULSES);
  state_e state, nxt;
  logic press, wrap, fire;
  logic [DW-1:0] div;
  logic [PW-1:0] pcnt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst(Reset),
    .raw(Button),
    .press(press)
  );
  assign wrap = div == DIV_LAST;
  assign fire = nxt == S_CYC || nxt == S_INSTR_P || (state == S_RUN && nxt == S_RUN && wrap);
  // next state; halt overrides every other event so no pulse is scheduled alongside it
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (press) nxt = mode == MODE_CYC ? S_CYC : mode == MODE_INSTR ? S_INSTR_P :
                                  mode == MODE_RUN ? S_RUN : S_IDLE;
      S_CYC:     nxt = S_IDLE;
      S_INSTR_P: nxt = S_INSTR_W;
      S_INSTR_W: nxt = (instr_done || pcnt == P_MAX) ? S_IDLE : S_INSTR_P;
      S_RUN:     if (press) nxt = S_IDLE;
      default:   nxt = state;
    endcase
    if (halt && state != S_HALTED) nxt = S_HALTED;
  end
  // state plus registered outputs, divider, pulse and step counters
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      cpu_step <= 1'b0;
      busy     <= 1'b0;
      running  <= 1'b0;
      fault    <= 1'b0;
      step_cnt <= '0;
      div      <= '0;
      pcnt     <= '0;
    end else begin
      state    <= nxt;
      cpu_step <= fire;
      busy     <= nxt != S_IDLE && nxt != S_HALTED;
      running  <= nxt == S_RUN;
      step_cnt <= step_cnt + STEP_W'(fire);
      div      <= (state == S_RUN && !wrap) ? div + 1'b1 : '0;
      pcnt     <= state == S_IDLE ? '0 : state == S_INSTR_P ? pcnt + 1'b1 : pcnt;
      fault    <= fault | (state == S_INSTR_W && !instr_done && pcnt == P_MAX && !halt);
    end
  end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: randomized directed scenarios against a pulse-timeline reference model
module tb_cpu_step_controller;
  localparam int DB = 4, RD = 5, MX = 8;
  logic clk = 1'b0, Reset = 1'b1, Button = 1'b0, halt = 1'b0, instr_done;
  logic cpu_step, busy, running, fault;
  logic [1:0] mode = 2'b00;
  logic [15:0] step_cnt;
  int n_tests = 0, n_fail = 0, exp_steps = 0;
  int cyc = 0, run_rise = -1, run_fall = -1, busy_cycles = 0;
  int pulses[$];
  logic run_q = 1'b0;
  int cpu_states = 3, cpu_phase = 0;
  logic cpu_live = 1'b1;

  always #5 clk = ~clk;

  cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .MAX_INSTR_PULSES(MX)) dut (
    .clk(clk),
    .Reset(Reset),
    .Button(Button),
    .mode(mode),
    .instr_done(instr_done),
    .halt(halt),
    .cpu_step(cpu_step),
    .busy(busy),
    .running(running),
    .fault(fault),
    .step_cnt(step_cnt)
  );

  // CPU stand-in: an instruction takes cpu_states enabled steps, fetch is phase 0
  assign instr_done = cpu_live && cpu_phase == 0;
  always @(posedge clk)
    if (Reset) cpu_phase <= 0;
    else if (cpu_step && cpu_live) cpu_phase <= (cpu_phase + 1) % cpu_states;

  // timeline recorder, sampled 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (Reset) run_q = 1'b0;
    else begin
      if (cpu_step) pulses.push_back(cyc);
      if (busy) busy_cycles++;
      if (running && !run_q) run_rise = cyc;
      if (!running && run_q) run_fall = cyc;
      run_q = running;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // random short glitches, a held press, then a release long enough to settle
  task automatic push_button(input int hold);
    int g;
    g = int'($urandom_range(1, 3));
    for (int i = 0; i < g; i++) begin
      Button = 1'b1;
      wait_cyc(int'($urandom_range(1, DB - 2)));
      Button = 1'b0;
      wait_cyc(1);
    end
    Button = 1'b1;
    wait_cyc(hold);
    Button = 1'b0;
    wait_cyc(DB + 4);
  endtask

  function automatic int bad_gaps(input int base, input int gap);
    int b = 0;
    for (int i = base + 1; i < pulses.size(); i++) if (pulses[i] - pulses[i-1] != gap) b++;
    return b;
  endfunction

  // free-run expectation: one pulse every RD cycles after entry e, none at or after exit x
  function automatic int run_misses(input int base, input int e, input int x);
    int m = 0, k = base;
    for (int t = e + RD; t < x; t += RD) begin
      if (k >= pulses.size() || pulses[k] != t) m++;
      k++;
    end
    if (pulses.size() > k) m += pulses.size() - k;
    return m;
  endfunction

  function automatic int count_upto(input int base, input int lim);
    int n = 0;
    for (int i = base; i < pulses.size(); i++) if (pulses[i] <= lim) n++;
    return n;
  endfunction

  initial begin
    int base, b0, en, p_obs, h;
    logic seen;
    wait_cyc(3);
    check("reset outputs", {cpu_step, busy, running, fault, step_cnt}, 0);
    Reset = 1'b0;
    wait_cyc(1);
    check("no pulse after reset", cpu_step, 0);

    // cycle-step: one press, one pulse, one busy cycle
    mode = 2'b00;
    for (int r = 0; r < 3; r++) begin
      base = pulses.size();
      b0 = busy_cycles;
      push_button(r == 0 ? 10 : int'($urandom_range(6, 15)));
      wait_cyc(5);
      exp_steps++;
      check("cyc pulses", pulses.size() - base, 1);
      check("cyc busy cycles", busy_cycles - b0, 1);
      check("cyc step_cnt", step_cnt, exp_steps % 65536);
    end

    // instruction step with a well-behaved CPU of random length, 8 is the boundary
    mode = 2'b01;
    for (int r = 0; r < 4; r++) begin
      cpu_states = r == 0 ? 3 : r == 1 ? MX : int'($urandom_range(1, MX));
      base = pulses.size();
      push_button(10);
      wait_cyc(20);
      exp_steps += cpu_states;
      check("instr pulses", pulses.size() - base, cpu_states);
      check("instr gaps", bad_gaps(base, 2), 0);
      check("instr fault", fault, 0);
      check("instr busy", busy, 0);
      check("instr step_cnt", step_cnt, exp_steps % 65536);
    end

    // instruction never completes: abort with sticky fault, further presses still step
    cpu_live = 1'b0;
    for (int r = 0; r < 2; r++) begin
      base = pulses.size();
      push_button(10);
      wait_cyc(20);
      exp_steps += MX;
      check("abort pulses", pulses.size() - base, MX);
      check("abort gaps", bad_gaps(base, 2), 0);
      check("abort fault", fault, 1);
      check("abort busy", busy, 0);
    end
    check("abort step_cnt", step_cnt, exp_steps % 65536);

    // hold mode ignores presses
    mode = 2'b11;
    base = pulses.size();
    b0 = busy_cycles;
    push_button(10);
    wait_cyc(5);
    check("hold pulses", pulses.size() - base, 0);
    check("hold busy", busy_cycles - b0, 0);

    // free-run: mode changes inside RUN are ignored, a second press stops it
    mode = 2'b10;
    base = pulses.size();
    push_button(10);
    mode = 2'($urandom_range(0, 3));
    wait_cyc(int'($urandom_range(16, 40)));
    push_button(10);
    wait_cyc(10);
    check("run timeline", run_misses(base, run_rise, run_fall), 0);
    check("run first 27", count_upto(base, run_rise + 27), 5);
    check("run stopped", {running, busy}, 0);
    exp_steps += pulses.size() - base;
    b0 = pulses.size();
    wait_cyc(20);
    check("run no more pulses", pulses.size() - b0, 0);
    check("run step_cnt", step_cnt, exp_steps % 65536);

    // halt on the cycle a pulse is due
    mode = 2'b10;
    base = pulses.size();
    push_button(10);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_cyc(1);
      seen = cpu_step;
    end
    check("run pulse seen", seen, 1);
    p_obs = cyc;
    wait_cyc(RD - 1);
    halt = 1'b1;
    h = p_obs + RD;
    wait_cyc(1);
    check("halt no pulse", cpu_step, 0);
    check("halt idle outs", {busy, running}, 0);
    wait_cyc(3);
    check("halt timeline", run_misses(base, run_rise, h), 0);
    halt = 1'b0;
    b0 = pulses.size();
    en = busy_cycles;
    push_button(10);
    push_button(10);
    check("halted ignores press", pulses.size() - b0, 0);
    check("halted busy", busy_cycles - en, 0);
    Reset = 1'b1;
    wait_cyc(1);
    Reset = 1'b0;
    wait_cyc(1);
    exp_steps = 0;
    check("reset clears steps", step_cnt, 0);
    check("reset clears fault", fault, 0);

    // reset mid-instruction, then 16-bit wrap of the step counter
    mode = 2'b01;
    cpu_live = 1'b0;
    Button = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_cyc(1);
      seen = cpu_step;
    end
    check("instr pulse seen", seen, 1);
    wait_cyc(1);
    check("in gap cycle", {busy, cpu_step}, 2'b10);
    Reset = 1'b1;
    Button = 1'b0;
    wait_cyc(1);
    check("mid reset outputs", {cpu_step, busy, running, fault, step_cnt}, 0);
    Reset = 1'b0;
    wait_cyc(1);
    check("no pulse after mid reset", cpu_step, 0);
    force dut.step_cnt = 16'hFFFF;
    wait_cyc(2);
    release dut.step_cnt;
    wait_cyc(1);
    check("preload", step_cnt, 16'hFFFF);
    mode = 2'b00;
    cpu_live = 1'b1;
    push_button(10);
    wait_cyc(3);
    check("step_cnt wrap", step_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
